// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions: opcode encodings and the memory-stage FSM states.
// The ALU compute stage imports the same package.
package mem_access_stage_pkg;

    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_LLB = 4'b1010;
    localparam logic [3:0] OP_LHB = 4'b1011;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_access_stage_ctr.sv
// Access timeout counter: 8-bit, synchronous clear and count enable,
// terminal-count flag when the count equals tc_val_i.
module mem_timeout_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] tc_val_i,
    output logic       tc_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = 8'd0;
        else if (en_i)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: LW/SW via a multi-cycle ready handshake with timeout,
// upstream stall while an access is outstanding, MEM/WB register, sticky HLT.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [3:0]  ex_opcode,
    input  logic [15:0] ex_addr,
    input  logic [15:0] ex_data,
    input  logic [3:0]  ex_rd,
    input  logic        ex_reg_we,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        wb_valid,
    output logic        wb_reg_we,
    output logic [3:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic        halted,
    output logic        mem_err
);

    localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_e  state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [15:0] mem_addr_q;
    logic [15:0] mem_wdata_q;
    logic [3:0]  rd_q;
    logic        wb_valid_q;
    logic        wb_reg_we_q;
    logic [3:0]  wb_rd_q;
    logic [15:0] wb_data_q;
    logic        halted_q;
    logic        mem_err_q;

    logic is_mem;
    logic start;
    logic waiting;
    logic tc;
    logic timeout_hit;

    always_comb begin
        is_mem      = ex_valid & is_mem_op(ex_opcode);
        start       = (state_q == ST_IDLE) & is_mem & ~halted_q;
        waiting     = (state_q == ST_WAIT) & ~mem_ready;
        timeout_hit = waiting & tc;
    end

    // Stall drops in the completing (or abandoning) cycle so upstream advances on that edge.
    assign stall = start | (waiting & ~timeout_hit);

    mem_timeout_ctr u_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (start),
        .en_i     (waiting & ~timeout_hit),
        .tc_val_i (TC_LAST),
        .tc_o     (tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            rd_q        <= 4'h0;
            wb_valid_q  <= 1'b0;
            wb_reg_we_q <= 1'b0;
            wb_rd_q     <= 4'h0;
            wb_data_q   <= 16'h0000;
            halted_q    <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ex_valid && !halted_q) begin
                        if (is_mem) begin
                            mem_addr_q  <= ex_addr;
                            mem_wdata_q <= ex_data;
                            mem_we_q    <= (ex_opcode == OP_SW);
                            rd_q        <= ex_rd;
                            mem_req_q   <= 1'b1;
                            wb_valid_q  <= 1'b0;
                            state_q     <= ST_WAIT;
                        end else begin
                            wb_valid_q  <= 1'b1;
                            wb_rd_q     <= ex_rd;
                            wb_data_q   <= ex_data;
                            if (ex_opcode == OP_HLT) begin
                                wb_reg_we_q <= 1'b0;
                                halted_q    <= 1'b1;
                            end else begin
                                wb_reg_we_q <= ex_reg_we;
                            end
                        end
                    end else begin
                        wb_valid_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        mem_req_q   <= 1'b0;
                        wb_valid_q  <= 1'b1;
                        wb_rd_q     <= rd_q;
                        wb_reg_we_q <= ~mem_we_q;
                        wb_data_q   <= mem_we_q ? mem_wdata_q : mem_rdata;
                        state_q     <= ST_IDLE;
                    end else if (timeout_hit) begin
                        // Abandoned access retires as a non-writing bubble with zero data.
                        mem_req_q   <= 1'b0;
                        mem_err_q   <= 1'b1;
                        wb_valid_q  <= 1'b1;
                        wb_rd_q     <= rd_q;
                        wb_reg_we_q <= 1'b0;
                        wb_data_q   <= 16'h0000;
                        state_q     <= ST_IDLE;
                    end else begin
                        wb_valid_q <= 1'b0;
                    end
                end
                default: begin
                    mem_req_q  <= 1'b0;
                    wb_valid_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_reg_we = wb_reg_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign halted    = halted_q;
    assign mem_err   = mem_err_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the 5-stage pipeline, directly downstream of the ALU compute stage. It takes the EX-stage address and result, performs LW/SW through a multi-cycle data-memory handshake, stalls upstream while an access is outstanding, and drives the MEM/WB pipeline register. Non-memory results pass to writeback in one cycle. HLT is latched here.

## Interface
- TIMEOUT_CYCLES, 255: cycles in WAIT without `mem_ready` before the access is abandoned (1..255).
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ex_valid  in  1  an EX result is presented this cycle.
- ex_opcode  in  4  instruction opcode (LW=4'b1000, SW=4'b1001, HLT=4'b1111).
- ex_addr  in  16  effective address from the ALU compute stage.
- ex_data  in  16  ALU result, or store data for SW.
- ex_rd  in  4  destination register.
- ex_reg_we  in  1  instruction writes `ex_rd`.
- stall  out  1  upstream must hold all `ex_*` inputs stable.
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = write (SW), 0 = read (LW).
- mem_addr  out  16  memory address.
- mem_wdata  out  16  store data.
- mem_rdata  in  16  load data; valid when `mem_ready` is high.
- mem_ready  in  1  access completes this cycle.
- wb_valid  out  1  MEM/WB entry valid.
- wb_reg_we  out  1  writeback enable.
- wb_rd  out  4  writeback register.
- wb_data  out  16  writeback data.
- halted  out  1  sticky; HLT has retired.
- mem_err  out  1  sticky; an access timed out.

## Operation
- `is_mem` = ex_valid & (ex_opcode==LW | ex_opcode==SW).
- FSM states: IDLE, WAIT.
- IDLE, `is_mem`, !halted:
  - capture addr, data, rd and LW/SW into holding registers.
  - set `mem_req`=1 and `mem_we`=(SW), clear the timeout counter, go to WAIT.
  - write `wb_valid`=0 that edge.
- IDLE, ex_valid and not memory, !halted:
  - wb_valid=1, wb_reg_we=ex_reg_we, wb_rd=ex_rd, wb_data=ex_data.
  - HLT instead writes wb_valid=1, wb_reg_we=0 and sets `halted`.
- IDLE, !ex_valid: write wb_valid=0.
- WAIT, `mem_ready`=1:
  - drop `mem_req` and return to IDLE.
  - LW: wb_valid=1, wb_reg_we=1, wb_data=mem_rdata.
  - SW: wb_valid=1, wb_reg_we=0, wb_data=held store data.
  - wb_rd=held rd.
- WAIT, !mem_ready:
  - increment the counter; wb_valid=0.
  - When the counter reaches TIMEOUT_CYCLES-1:
    - drop `mem_req`, set `mem_err`, go to IDLE.
    - wb_valid=1, wb_reg_we=0, wb_data=16'h0000.
- stall = (IDLE & `is_mem` & !halted) | (WAIT & !mem_ready & !timeout_hit).
- Once `halted` is set, all ex_valid inputs are ignored: wb_valid stays 0 and stall stays 0. An access already in WAIT still completes normally.
- mem_addr, mem_wdata and mem_we come from the holding registers only, and are stable for the whole WAIT.

## Timing
- Reset (rst_n low at an edge) sets:
  - state=IDLE and counter=0.
  - mem_req, mem_we, wb_valid, wb_reg_we, halted, mem_err = 0.
  - wb_rd=0, wb_data=0, mem_addr=0, mem_wdata=0.
- Reset mid-WAIT abandons the access with no writeback. `mem_req` is low in the next cycle.
- Non-memory op presented in cycle N: wb_* valid in cycle N+1, with no stall.
- Memory op presented in cycle N:
  - stall is high in N; `mem_req` goes high from N+1.
  - If mem_ready arrives in cycle M ≥ N+1, then stall is low in M, wb_* is valid in M+1, and upstream presents the next op in M+1.
  - Minimum total: 2 stall-free-edge cycles, with writeback at N+2.
- mem_ready while in IDLE is ignored.
- Back-to-back LW→LW: the second op enters IDLE in M+1, so `mem_req` drops for exactly one cycle between the two accesses.

## Structure
- Shared pipeline package holds the opcode constants (LW, SW, LLB, LHB, HLT) and the FSM state encoding; the ALU compute stage uses the same package.
- One sub-module, `mem_timeout_ctr`: an 8-bit counter with clear/enable and a terminal-count output.

## Test plan
- ADD result: ex_data=16'h1234, rd=3, reg_we=1, no stall → next cycle wb_valid=1, wb_rd=3, wb_data=16'h1234.
- LW at addr 16'h0040, mem_ready 3 cycles after mem_req rises with rdata=16'hBEEF:
  - stall for 4 cycles.
  - mem_addr=16'h0040 held throughout.
  - wb_data=16'hBEEF, wb_reg_we=1.
- SW addr 16'h0010, data 16'h00AA, mem_ready on the first mem_req cycle → mem_we=1, mem_wdata=16'h00AA, wb_valid=1, wb_reg_we=0, and mem_req high for exactly 1 cycle.
- LW with mem_ready never asserted and TIMEOUT_CYCLES=4:
  - mem_req drops after 4 WAIT cycles.
  - mem_err=1, wb_data=0, wb_reg_we=0, stall released.
- HLT followed by ADD held valid → halted=1; the ADD never produces wb_valid.
- rst_n low during WAIT → next cycle mem_req=0, state IDLE, no writeback; a later LW works normally.
